// File: rtl/l1a_smp_tagger_if.sv
// Sample/L1A tagging bus: ADC sample and L1A strobes in, delayed sample plus tag word out.
interface l1a_smp_tagger_if;
    logic [6:0]  SAMP_MAX;
    logic        L1A;
    logic        L1A_MATCH;
    logic [11:0] WDATA_IN;
    logic        WREN_IN;
    logic [11:0] WDATA;
    logic        WREN;
    logic [43:0] L1A_SMP_DATA;
    logic        L1A_WRT_EN;
    logic        COLL_ERR;
    logic        OVF_ERR;

    modport master (
        output SAMP_MAX, L1A, L1A_MATCH, WDATA_IN, WREN_IN,
        input  WDATA, WREN, L1A_SMP_DATA, L1A_WRT_EN, COLL_ERR, OVF_ERR
    );

    modport slave (
        input  SAMP_MAX, L1A, L1A_MATCH, WDATA_IN, WREN_IN,
        output WDATA, WREN, L1A_SMP_DATA, L1A_WRT_EN, COLL_ERR, OVF_ERR
    );
endinterface

// File: rtl/l1a_smp_tagger.sv
// Tags each ADC sample with L1A counters, phase and open-window overlap info; 1-clock latency.
module l1a_smp_tagger #(
    parameter int unsigned WIN_DEPTH = 16,
    parameter int unsigned HALF_PER  = 3
) (
    input logic             CLK,
    input logic             RST_RESYNC_N,
    l1a_smp_tagger_if.slave tag_if
);
    localparam int unsigned PtrW = (WIN_DEPTH > 1) ? $clog2(WIN_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(WIN_DEPTH + 1);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(WIN_DEPTH - 1);
    localparam logic [CntW-1:0] CntFull = CntW'(WIN_DEPTH);

    logic [7:0]      pcnt_q, pcnt_d;
    logic [23:0]     l1acnt_q, l1acnt_d;
    logic [11:0]     l1amcnt_q, l1amcnt_d;
    logic [15:0]     sidx_q, sidx_d;
    logic            pend_q, pend_d;
    logic            pend_phase_q, pend_phase_d;
    logic            seen_q, seen_d;
    logic            coll_q, coll_d;
    logic            ovf_q, ovf_d;
    logic [15:0]     win_q [WIN_DEPTH];
    logic [15:0]     win_d [WIN_DEPTH];
    logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [11:0]     wdata_q, wdata_d;
    logic            wren_q, wren_d;
    logic [43:0]     smp_data_q, smp_data_d;

    logic            phase_now, pend_eff, phase_eff, push, rejected, pop;
    logic [15:0]     win_len, push_end, head_end;
    logic [CntW-1:0] n_occ;
    logic [3:0]      ovl_cnt;

    always_comb begin
        pcnt_d       = pcnt_q;
        l1acnt_d     = l1acnt_q;
        l1amcnt_d    = l1amcnt_q;
        sidx_d       = sidx_q;
        pend_d       = pend_q;
        pend_phase_d = pend_phase_q;
        seen_d       = seen_q;
        coll_d       = coll_q;
        ovf_d        = ovf_q;
        win_d        = win_q;
        head_d       = head_q;
        tail_d       = tail_q;
        cnt_d        = cnt_q;
        smp_data_d   = smp_data_q;
        wdata_d      = tag_if.WDATA_IN;
        wren_d       = tag_if.WREN_IN;
        push         = 1'b0;
        rejected     = 1'b0;
        pop          = 1'b0;
        n_occ        = cnt_q;
        ovl_cnt      = 4'd0;
        head_end     = win_q[head_q];

        win_len   = (tag_if.SAMP_MAX == 7'd0) ? 16'd1 : {9'd0, tag_if.SAMP_MAX};
        push_end  = sidx_q + win_len - 16'd1;
        phase_now = 32'(pcnt_q) >= HALF_PER;

        // Only the first matched L1A of a slot opens a window and fixes the phase.
        pend_eff  = pend_q | (tag_if.L1A & tag_if.L1A_MATCH);
        phase_eff = pend_q ? pend_phase_q : phase_now;

        if (tag_if.L1A) begin
            l1acnt_d = l1acnt_q + 24'd1;
            if (tag_if.L1A_MATCH) l1amcnt_d = l1amcnt_q + 12'd1;
            if (seen_q || pend_q) coll_d = 1'b1;
        end

        if (!tag_if.WREN_IN) begin
            pcnt_d       = (pcnt_q == 8'hFF) ? pcnt_q : pcnt_q + 8'd1;
            seen_d       = seen_q | tag_if.L1A;
            pend_d       = pend_eff;
            pend_phase_d = phase_eff;
        end else begin
            pcnt_d   = 8'd0;
            seen_d   = 1'b0;
            pend_d   = 1'b0;
            push     = pend_eff && (cnt_q != CntFull);
            rejected = pend_eff && (cnt_q == CntFull);
            if (rejected) ovf_d = 1'b1;

            n_occ    = cnt_q + CntW'(push);
            head_end = (cnt_q == '0) ? push_end : win_q[head_q];
            pop      = (n_occ != '0) && (head_end == sidx_q);

            if (push) begin
                win_d[tail_q] = push_end;
                tail_d        = (tail_q == PtrLast) ? '0 : tail_q + PtrW'(1);
            end
            if (pop) head_d = (head_q == PtrLast) ? '0 : head_q + PtrW'(1);
            cnt_d = n_occ - CntW'(pop);

            if (n_occ == '0)              ovl_cnt = 4'd0;
            else if (32'(n_occ) > 32'd16) ovl_cnt = 4'd15;
            else                          ovl_cnt = 4'(n_occ - CntW'(1));

            smp_data_d = {32'(n_occ) >= 32'd3, 32'(n_occ) >= 32'd2, push & phase_eff, push,
                          ovl_cnt, l1amcnt_d, l1acnt_d};
            sidx_d     = sidx_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_RESYNC_N) begin
            pcnt_q       <= '0;
            l1acnt_q     <= '0;
            l1amcnt_q    <= '0;
            sidx_q       <= '0;
            pend_q       <= 1'b0;
            pend_phase_q <= 1'b0;
            seen_q       <= 1'b0;
            coll_q       <= 1'b0;
            ovf_q        <= 1'b0;
            win_q        <= '{default: '0};
            head_q       <= '0;
            tail_q       <= '0;
            cnt_q        <= '0;
            wdata_q      <= '0;
            wren_q       <= 1'b0;
            smp_data_q   <= '0;
        end else begin
            pcnt_q       <= pcnt_d;
            l1acnt_q     <= l1acnt_d;
            l1amcnt_q    <= l1amcnt_d;
            sidx_q       <= sidx_d;
            pend_q       <= pend_d;
            pend_phase_q <= pend_phase_d;
            seen_q       <= seen_d;
            coll_q       <= coll_d;
            ovf_q        <= ovf_d;
            win_q        <= win_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            cnt_q        <= cnt_d;
            wdata_q      <= wdata_d;
            wren_q       <= wren_d;
            smp_data_q   <= smp_data_d;
        end
    end

    assign tag_if.WDATA        = wdata_q;
    assign tag_if.WREN         = wren_q;
    assign tag_if.L1A_WRT_EN   = wren_q;
    assign tag_if.L1A_SMP_DATA = smp_data_q;
    assign tag_if.COLL_ERR     = coll_q;
    assign tag_if.OVF_ERR      = ovf_q;
endmodule

// File: doc/l1a_smp_tagger.md
Name: l1a_smp_tagger

Overview:
- Upstream neighbour of the DAQ ring buffer. Tags every ADC sample with L1A bookkeeping and forwards the sample data with matched latency.
- Per-sample outputs: start-of-window flag, L1A phase, overlap flags/count, 24-bit L1A count, 12-bit matched-L1A count. These are packed as the 44-bit L1A_SMP_DATA word plus L1A_WRT_EN/WDATA/WREN.
- Tracks up to 16 concurrently open readout windows of SAMP_MAX samples each.

Parameters:
- WIN_DEPTH, 16, maximum simultaneously open windows (depth of the window-end queue).
- HALF_PER, 3, clock count since the last sample at or above which an L1A is tagged late phase.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST_RESYNC_N  in  1  synchronous, active-low reset.
- SAMP_MAX  in  7  window length in samples; 0 is treated as 1.
- L1A  in  1  L1A strobe, one clock.
- L1A_MATCH  in  1  valid only with L1A; high means the L1A is matched to this board.
- WDATA_IN  in  12  ADC sample.
- WREN_IN  in  1  sample strobe.
- WDATA  out  12  WDATA_IN delayed 1 clock.
- WREN  out  1  WREN_IN delayed 1 clock.
- L1A_SMP_DATA  out  44  {multi_ovlp, ovrlap, l1a_phase, l1a_match, ovrlap_cnt[3:0], l1amcnt[11:0], l1acnt[23:0]}.
- L1A_WRT_EN  out  1  equals WREN; qualifies L1A_SMP_DATA.
- COLL_ERR  out  1  sticky: two or more L1As fell into one sample slot.
- OVF_ERR  out  1  sticky: a matched window was rejected because the queue was full.

Behaviour:
- Reset: all outputs, counters, pending state and the queue are cleared to 0. Reset mid-window discards every open window.
- Latency: 1 clock. WDATA, WREN, L1A_WRT_EN and L1A_SMP_DATA are registered together. All fields describe the sample presented on WREN_IN in the previous cycle.
- Phase counter (pcnt, 8-bit, saturating):
  - Cleared on a WREN_IN cycle; incremented otherwise.
  - Phase for an L1A is (pcnt >= HALF_PER), evaluated in the L1A cycle.
- L1A capture:
  - Every L1A increments l1acnt (24-bit, wraps at 2^24).
  - A matched L1A also increments l1amcnt (12-bit, wraps) and sets pending, with its phase latched.
  - An L1A in the same cycle as WREN_IN is applied to that sample.
  - A second L1A while pending is already set (or a second L1A in the same slot):
    - both counters still increment;
    - no second window is opened;
    - latched phase is kept from the first L1A;
    - COLL_ERR is set.
- Per sample (WREN_IN=1), in this order:
  - If pending and queue not full:
    - push end index = sidx + max(SAMP_MAX,1) - 1 (16-bit modulo) into the queue;
    - l1a_match = 1; l1a_phase = latched phase;
    - clear pending.
  - If pending and queue full: l1a_match = 0, OVF_ERR set, pending cleared.
  - No pending: l1a_match = 0, l1a_phase = 0.
  - n = queue occupancy after any push:
    - ovrlap_cnt = n-1, saturating at 15 (0 if n = 0);
    - ovrlap = (n >= 2);
    - multi_ovlp = (n >= 3).
  - Pop every head entry whose end == sidx. Ends are monotonic, so at most one entry pops per sample. A push and a pop in the same sample are allowed.
  - Then sidx increments (16-bit, wraps).
- Counter fields: l1acnt/l1amcnt are output as the values after any increment from an L1A applied to the sample.
- Non-sample cycles: L1A_SMP_DATA holds its last value; L1A_WRT_EN = 0.
- Error flags clear only on reset.

Test Plan:
- Reset release, SAMP_MAX=4, one matched L1A with sample 0, samples every 6 clocks:
  - sample 0 out 1 clk later with l1a_match=1, l1acnt=1, l1amcnt=1, ovrlap_cnt=0;
  - samples 1-3 l1a_match=0, ovrlap=0;
  - queue empty after sample 3.
- Unmatched L1A, then matched L1A two samples later:
  - unmatched sample: l1acnt=1, l1amcnt=0, l1a_match=0;
  - matched sample: l1acnt=2, l1amcnt=1, l1a_match=1.
- Phase, HALF_PER=3:
  - L1A 2 clocks after a sample -> phase 0;
  - L1A 4 clocks after a sample -> phase 1, reported on the next sample.
- SAMP_MAX=8, matched L1As at samples 0, 2, 4:
  - sample 4: ovrlap_cnt=2, ovrlap=1, multi_ovlp=1;
  - sample 8: ovrlap_cnt=1, ovrlap=1, multi_ovlp=0 (window 0 closed at 7).
- Two L1As within one sample slot -> l1acnt +2, one window, COLL_ERR=1.
- SAMP_MAX=127, 17 matched L1As on consecutive samples:
  - 17th sample l1a_match=0, OVF_ERR=1, ovrlap_cnt=15;
  - reset low for 1 clk -> all outputs 0, flags cleared.
